spi_reg_sequencer: RTL
======================

Name: spi_reg_sequencer

Overview:
Register-access front end for the team's byte-stream SPI master; sits directly upstream of it.
Turns one read/write command into a framed byte burst: command/address bytes, then data bytes, MSB first.
Keeps the byte stream to the master unbroken so chip-select stays asserted for the whole frame.
Counts returned RX bytes, assembles read data, and returns a single response per command.

Parameters:
ADDR_BYTES, 2, bytes in address phase (1..4); bit 7 of first byte = R/W flag, ADDR_W = 8*ADDR_BYTES-1.
DATA_BYTES, 1, bytes in data phase (1..4); DATA_W = 8*DATA_BYTES.
TIMEOUT_CYCLES, 65535, drain watchdog limit in clk cycles (used only with the optional feature).

Ports:
clk  in  1  fabric clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accept
cmd_rw  in  1  1 = read, 0 = write
cmd_addr  in  ADDR_W  register address
cmd_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  response available
rsp_ready  in  1  response accept
rsp_rdata  out  DATA_W  bytes captured during the data phase
rsp_err  out  1  timeout flag
busy  out  1  high from command accept until response handshake
spi_tx_data  out  8  byte to SPI master
spi_tx_valid  out  1  byte valid
spi_tx_ready  in  1  master accepts byte
spi_rx_data  in  8  byte from SPI master
spi_rx_valid  in  1  one-cycle pulse per completed byte

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, spi_tx_valid=0, spi_tx_data=0, state=S_IDLE.
- cmd_ready becomes 1 on the first cycle after rst deasserts.
- Frame: TOTAL = ADDR_BYTES+DATA_BYTES bytes, built as {cmd_rw, cmd_addr, payload}.
  - payload = cmd_wdata for a write, all zeros for a read.
  - Bytes are shifted out MSB first.
- S_IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: load the frame shift register, clear tx_cnt/rx_cnt/rdata, set busy, go to S_SEND, drop cmd_ready.
- S_SEND:
  - spi_tx_valid=1; spi_tx_data = top byte of the shift register.
  - spi_tx_data is held stable while spi_tx_ready=0.
  - On spi_tx_valid&&spi_tx_ready: shift by 8 and increment tx_cnt. The next byte is valid the following cycle, so there is no gap.
  - On the handshake where tx_cnt==TOTAL-1: go to S_DRAIN; spi_tx_valid=0 the next cycle.
- S_SEND and S_DRAIN, on each spi_rx_valid:
  - rx_cnt is incremented.
  - If rx_cnt >= ADDR_BYTES, rdata = {rdata[DATA_W-9:0], spi_rx_data}.
  - Address-phase RX bytes are discarded.
- S_DRAIN:
  - On spi_rx_valid with rx_cnt==TOTAL-1: go to S_RESP; rsp_rdata is valid the same cycle rsp_valid rises.
  - This completion check applies only in S_DRAIN.
  - An rx count reaching TOTAL while still in S_SEND is impossible by master timing. If it occurs anyway, extra pulses are ignored once rx_cnt==TOTAL.
- S_RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On handshake: rsp_valid=0, busy=0, go to S_IDLE.
  - cmd_ready=1 the cycle after the handshake, so the minimum command-to-command spacing is one idle cycle.
- Writes also return a response; rsp_rdata holds the MISO bytes seen during the data phase.
- spi_rx_valid in S_IDLE or S_RESP is ignored.
- rst mid-operation:
  - Next cycle: state=S_IDLE, spi_tx_valid=0, no response is generated, and partial rdata is discarded.
  - The downstream master shares rst.
- Counters are $clog2(TOTAL+1) bits wide and never wrap within a frame.

Optional Feature:
Macro SPI_REG_SEQUENCER_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to S_DRAIN and increments each cycle in S_DRAIN.
  - On reaching TIMEOUT_CYCLES without completion: go to S_RESP with rsp_err=1 and rsp_rdata = partial assembled value.
  - rsp_err clears on the response handshake.
- Not defined: no watchdog logic; rsp_err is tied to 0; S_DRAIN waits indefinitely.

Test Plan:
1. Write, ADDR_BYTES=2, DATA_BYTES=1, cmd_addr=0x1234, cmd_wdata=0xA5, master model always ready:
   - spi_tx bytes are 0x12, 0x34, 0xA5 on consecutive accepts with no valid gap.
   - rsp_valid=1 after the 3rd rx pulse; rsp_err=0.
2. Read, cmd_addr=0x0055, rx model returns 0x11, 0x22, 0x3C:
   - tx bytes are 0x80, 0x55, 0x00.
   - rsp_rdata=0x3C.
   - DATA_BYTES=2 variant: rx model returns 0x11, 0x22, 0x3C, 0x4D; expect rsp_rdata=0x3C4D.
3. spi_tx_ready low for 7 cycles during byte 2:
   - spi_tx_data held at 0x34 and spi_tx_valid held at 1 throughout.
4. rsp_ready held low for 10 cycles:
   - rsp_valid and rsp_rdata stable; cmd_ready=0; busy=1.
   - After the handshake, a pending cmd_valid is accepted on the 2nd cycle.
5. rst pulsed in S_SEND after the first tx accept:
   - Next cycle spi_tx_valid=0 and cmd_ready=0; one cycle later cmd_ready=1.
   - No rsp_valid.
   - The next command frames correctly from byte 0.
6. With SPI_REG_SEQUENCER_TIMEOUT_EN, TIMEOUT_CYCLES=100, rx model drops the last rx pulse:
   - rsp_valid with rsp_err=1 exactly 100 cycles after entering S_DRAIN.
   - rsp_err=0 on the next normal command.

Source files
------------

// File: rtl/spi_reg_sequencer.sv
// spi_reg_sequencer: turns one register read/write command into a framed,
// gap-free MSB-first byte burst for the byte-stream SPI master, assembles
// the data-phase RX bytes and returns exactly one response per command.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/ready           command handshake
//   cmd_rw, cmd_addr          1 = read; register address (8*ADDR_BYTES-1 bits)
//   cmd_wdata                 write data (8*DATA_BYTES bits)
//   rsp_valid/ready           response handshake
//   rsp_rdata, rsp_err        data-phase MISO bytes; drain timeout flag
//   busy                      high from command accept to response handshake
//   spi_tx_data/valid/ready   byte stream towards the SPI master
//   spi_rx_data/valid         completed bytes from the SPI master
//
// Optional: define SPI_REG_SEQUENCER_TIMEOUT_EN to add a drain watchdog of
// TIMEOUT_CYCLES clocks; otherwise rsp_err is tied low and drain waits.

module spi_reg_sequencer #(
    parameter int ADDR_BYTES     = 2,
    parameter int DATA_BYTES     = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_rw,
    input  logic [8*ADDR_BYTES-2:0] cmd_addr,
    input  logic [8*DATA_BYTES-1:0] cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [8*DATA_BYTES-1:0] rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [7:0]              spi_tx_data,
    output logic                    spi_tx_valid,
    input  logic                    spi_tx_ready,
    input  logic [7:0]              spi_rx_data,
    input  logic                    spi_rx_valid
);

    localparam int DATA_W  = 8 * DATA_BYTES;
    localparam int TOTAL   = ADDR_BYTES + DATA_BYTES;
    localparam int FRAME_W = 8 * TOTAL;
    localparam int CW      = $clog2(TOTAL + 1);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
    localparam logic [CW-1:0] FULL = CW'(TOTAL);
    localparam logic [CW-1:0] ABYT = CW'(ADDR_BYTES);

    if (ADDR_BYTES < 1 || ADDR_BYTES > 4 ||
        DATA_BYTES < 1 || DATA_BYTES > 4 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("spi_reg_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_cmd_ready;
    logic [FRAME_W-1:0]  r_shift;
    logic [CW-1:0]       r_tx_cnt;
    logic [CW-1:0]       r_rx_cnt;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   w_rdata_shift;
    logic [DATA_W-1:0]   w_payload;
    logic                w_cmd_fire;
    logic                w_tx_fire;
    logic                w_rx_take;
    logic                w_rx_last;
    logic                w_timeout;

    assign w_cmd_fire = (r_state == S_IDLE) && cmd_valid && r_cmd_ready;
    assign w_tx_fire  = (r_state == S_SEND) && spi_tx_ready;
    // Pulses beyond a full frame are dropped so the counter cannot wrap.
    assign w_rx_take  = spi_rx_valid && (r_rx_cnt != FULL) &&
                        (r_state == S_SEND || r_state == S_DRAIN);
    assign w_rx_last  = spi_rx_valid && (r_state == S_DRAIN) &&
                        (r_rx_cnt == LAST);
    assign w_payload  = cmd_rw ? {DATA_W{1'b0}} : cmd_wdata;

    if (DATA_BYTES == 1) begin : g_rd1
        assign w_rdata_shift = spi_rx_data;
    end else begin : g_rdn
        assign w_rdata_shift = {r_rdata[DATA_W-9:0], spi_rx_data};
    end

    // cmd_ready is registered so it stays low for the cycle in which reset
    // is applied and rises one cycle after reset or a response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cmd_ready <= (w_next_state == S_IDLE);
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (w_cmd_fire) w_next_state = S_SEND;
            S_SEND:  if (w_tx_fire && r_tx_cnt == LAST) w_next_state = S_DRAIN;
            S_DRAIN: if (w_rx_last || w_timeout) w_next_state = S_RESP;
            S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        rsp_valid    = 1'b0;
        spi_tx_valid = 1'b0;
        unique case (r_state)
            S_SEND: begin
                busy         = 1'b1;
                spi_tx_valid = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            S_RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign cmd_ready   = r_cmd_ready;
    assign spi_tx_data = r_shift[FRAME_W-1 -: 8];
    assign rsp_rdata   = r_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift  <= '0;
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_shift  <= {cmd_rw, cmd_addr, w_payload};
                r_tx_cnt <= '0;
                r_rx_cnt <= '0;
                r_rdata  <= '0;
            end
            if (w_tx_fire) begin
                r_shift  <= r_shift << 8;
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
            if (w_rx_take) begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
                if (r_rx_cnt >= ABYT) r_rdata <= w_rdata_shift;
            end
        end
    end

`ifdef SPI_REG_SEQUENCER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_err;

    // Held at zero outside drain, so it starts from zero on every entry.
    assign w_timeout = (r_state == S_DRAIN) && (r_wdog == WD_LAST);
    assign rsp_err   = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_DRAIN) r_wdog <= r_wdog + 1'b1;
            else                    r_wdog <= '0;
            if (w_timeout && !w_rx_last)          r_err <= 1'b1;
            if (r_state == S_RESP && rsp_ready)   r_err <= 1'b0;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

endmodule
